// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling tile reader: FSM states, pooling
// modes and the in-window address offset.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } pool_state_t;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  // Offset of sample k inside a 2x2 window of a row-major tile.
  function automatic int off(input int k, input int tile_dim);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return tile_dim;
      default: return tile_dim + 1;
    endcase
  endfunction

endpackage

// File: rtl/pool_reduce_unit.sv
// Four-sample reducer: signed max or floor-average. The result port reflects
// the value including the sample presented this cycle.
module pool_reduce_unit
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  acc_en,
  input  pool_mode_t            mode,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] result
);

  // Two guard bits hold the sum of four samples without overflow.
  logic signed [DATA_WIDTH+1:0] acc_reg;
  logic signed [DATA_WIDTH+1:0] acc_next;
  logic signed [DATA_WIDTH+1:0] din_ext;

  always_comb begin
    din_ext  = {{2{din[DATA_WIDTH-1]}}, din};
    acc_next = acc_reg;
    if (init) begin
      acc_next = din_ext;
    end else if (acc_en) begin
      if (mode == POOL_AVG) begin
        acc_next = acc_reg + din_ext;
      end else if (din_ext > acc_reg) begin
        acc_next = din_ext;
      end
    end
    result = (mode == POOL_AVG) ? DATA_WIDTH'(acc_next >>> 2) : DATA_WIDTH'(acc_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/pool_tile_reader.sv
// Walks a square tile in 2x2 windows, reads each window from the register file
// and streams one pooled value per window on a valid/ready interface.
module pool_tile_reader
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_DIM   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pool_mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDX_WIDTH-1:0]  res_idx
);

  localparam int HALF   = TILE_DIM / 2;
  localparam int LAST_W = HALF * HALF - 1;

  pool_state_t           state_reg, state_next;
  pool_mode_t            mode_reg;
  logic [1:0]            k_reg;
  logic [IDX_WIDTH-1:0]  w_reg;
  logic                  done_reg;
  logic [DATA_WIDTH-1:0] res_data_reg;
  logic [DATA_WIDTH-1:0] reduce_result;
  logic                  last_w;
  logic                  sample_init;
  logic                  sample_en;

  assign last_w = (w_reg == IDX_WIDTH'(LAST_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (k_reg == 2'd3) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (res_ready) state_next = last_w ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  // Read data trails the address by a cycle, so samples land at k=1..3 and DRAIN.
  always_comb begin
    busy        = (state_reg != IDLE);
    res_valid   = (state_reg == OUT);
    sample_init = (state_reg == ISSUE) && (k_reg == 2'd1);
    sample_en   = ((state_reg == ISSUE) && (k_reg != 2'd0)) || (state_reg == DRAIN);
    rd_addr     = '0;
    if (state_reg == ISSUE) begin
      rd_addr = ADDR_WIDTH'(2 * TILE_DIM * (int'(w_reg) / HALF) + 2 * (int'(w_reg) % HALF)
                            + off(int'(k_reg), TILE_DIM));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg     <= POOL_MAX;
      k_reg        <= '0;
      w_reg        <= '0;
      done_reg     <= 1'b0;
      res_data_reg <= '0;
    end else begin
      done_reg <= (state_reg == OUT) && res_ready && last_w;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg <= pool_mode_t'(pool_mode);
            w_reg    <= '0;
            k_reg    <= '0;
          end
        end
        ISSUE:   k_reg <= k_reg + 2'd1;
        DRAIN:   res_data_reg <= reduce_result;
        OUT: begin
          if (res_ready && !last_w) begin
            w_reg <= w_reg + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  pool_reduce_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .clk    (clk),
    .rst    (rst),
    .init   (sample_init),
    .acc_en (sample_en),
    .mode   (mode_reg),
    .din    (rd_data),
    .result (reduce_result)
  );

  assign done     = done_reg;
  assign res_data = res_data_reg;
  assign res_idx  = w_reg;

endmodule

// File: tb/tb_pool_tile_reader.sv
// Directed bench for pool_tile_reader: expected results go into a scoreboard
// queue and a negedge monitor pops them on every result handshake.
module tb_pool_tile_reader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pool_mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [IW-1:0] res_idx;

  logic [DW-1:0] mem [16];

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   addr_tab [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  pool_tile_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pool_mode (pool_mode),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  // Register file model with a registered read port.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0h idx %0d, want no result", res_data, res_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result idx=%0d data=%0h (expect idx=%0d data=%0h)", res_idx, res_data, e.idx, e.data);
        check("res_data", res_data, e.data);
        check("res_idx", res_idx, e.idx);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    e.data = a; e.idx = 2'd0; sb.push_back(e);
    e.data = b; e.idx = 2'd1; sb.push_back(e);
    e.data = c; e.idx = 2'd2; sb.push_back(e);
    e.data = d; e.idx = 2'd3; sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Full max-mode tile on data mem[i]=i with cycle-exact address/valid/done checks.
  task automatic run_max_seq(input string tag);
    push4(16'd5, 16'd7, 16'd13, 16'd15);
    for (int c = 0; c <= 25; c++) begin
      int ea;
      start     = (c == 0);
      pool_mode = 1'b0;
      ea = 0;
      if (c >= 1 && c <= 24 && ((c - 1) % 6) < 4) ea = addr_tab[((c - 1) / 6) * 4 + (c - 1) % 6];
      @(negedge clk);
      check({tag, "_rd_addr"}, rd_addr, ea);
      check({tag, "_res_valid"}, res_valid, 32'(c > 0 && c <= 24 && c % 6 == 0));
      check({tag, "_done"}, done, 32'(c == 25));
      check({tag, "_busy"}, busy, 32'(c >= 1 && c <= 24));
      next_cycle();
    end
    start = 1'b0;
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 20000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pool_mode = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);

    next_cycle();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_idx", res_idx, 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Max mode, ready held high.
    run_max_seq("max");

    // Signed average and signed max on negative window 0.
    mem[0] = 16'hFFFC; mem[1] = 16'hFFFD; mem[4] = 16'hFFFE; mem[5] = 16'hFFFF;
    push4(16'hFFFD, 16'd4, 16'd10, 16'd12);
    start = 1'b1; pool_mode = 1'b1;
    next_cycle();
    start = 1'b0; pool_mode = 1'b0;
    wait_done("avg_neg");
    push4(16'hFFFF, 16'd7, 16'd13, 16'd15);
    start = 1'b1; pool_mode = 1'b0;
    next_cycle();
    start = 1'b0;
    wait_done("max_neg");
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);

    // Backpressure on window 1 for 10 cycles.
    push4(16'd5, 16'd7, 16'd13, 16'd15);
    for (int c = 0; c <= 23; c++) begin
      start     = (c == 0);
      res_ready = !(c >= 12 && c <= 21);
      @(negedge clk);
      if (c >= 12 && c <= 21) begin
        check("bp_res_valid", res_valid, 1);
        check("bp_res_data", res_data, 7);
        check("bp_res_idx", res_idx, 1);
        check("bp_rd_addr", rd_addr, 0);
      end
      if (c == 22) check("bp_release_valid", res_valid, 1);
      if (c == 23) check("bp_w2_first_addr", rd_addr, 8);
      next_cycle();
    end
    start = 1'b0; res_ready = 1'b1;
    wait_done("bp");

    // Starts in ISSUE and OUT ignored; start in the done cycle restarts.
    push4(16'd5, 16'd7, 16'd13, 16'd15);
    for (int c = 0; c <= 27; c++) begin
      start     = (c == 0 || c == 2 || c == 6 || c == 25);
      pool_mode = (c != 0);
      if (c == 25) push4(16'd2, 16'd4, 16'd10, 16'd12);
      @(negedge clk);
      if (c == 25) check("restart_done_cycle", done, 1);
      if (c == 26) check("restart_busy", busy, 1);
      if (c == 27) check("restart_rd_addr", rd_addr, 1);
      next_cycle();
    end
    start = 1'b0; pool_mode = 1'b0;
    wait_done("restart");

    // Reset during window 2 ISSUE k=1, then a clean rerun.
    push4(16'd5, 16'd7, 16'd0, 16'd0);
    void'(sb.pop_back());
    void'(sb.pop_back());
    for (int c = 0; c <= 15; c++) begin
      start = (c == 0);
      rst   = (c == 14);
      @(negedge clk);
      if (c == 14) check("rst_mid_rd_addr", rd_addr, 0);
      if (c == 15) begin
        check("rst_mid_busy", busy, 0);
        check("rst_mid_res_valid", res_valid, 0);
        check("rst_mid_rd_addr_next", rd_addr, 0);
        check("rst_mid_res_data", res_data, 0);
      end
      next_cycle();
    end
    start = 1'b0; rst = 1'b0;
    check("rst_mid_sb_empty", sb.size(), 0);
    run_max_seq("after_rst");

    // pool_mode flipped during window 1 has no effect.
    push4(16'd2, 16'd4, 16'd10, 16'd12);
    start = 1'b1; pool_mode = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (7) next_cycle();
    pool_mode = 1'b0;
    wait_done("mode_toggle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
